// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: pixel-enable divider, PIX/LINE scan counters and
// sync/DE/blanking outputs aligned to the image source's one-CE registered RGB.
module vga_timing_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  output logic       CE,
  output logic [9:0] PIX,
  output logic [9:0] LINE,
  input  logic [2:0] R_IN,
  input  logic [2:0] G_IN,
  input  logic [1:0] B_IN,
  output logic [2:0] VGA_R,
  output logic [2:0] VGA_G,
  output logic [1:0] VGA_B,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       DE,
  output logic       FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       PIX_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]       LINE_LAST = 10'(V_TOTAL - 1);
  // 11-bit bounds so a range ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e           state_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       pix_q, pix_d;
  logic [9:0]       line_q, line_d;
  logic             de_q, de_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             running, ce, frame_end, to_idle;

  always_comb begin
    running   = (state_q != IDLE);
    ce        = running && (div_q == DIV_LAST);
    frame_end = ce && (pix_q == PIX_LAST) && (line_q == LINE_LAST);
    to_idle   = (state_q == DRAIN) && !EN && frame_end;

    div_d  = (!running || div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pix_d  = (pix_q == PIX_LAST) ? '0 : pix_q + 10'd1;
    line_d = line_q;
    if (pix_q == PIX_LAST) begin
      line_d = (line_q == LINE_LAST) ? '0 : line_q + 10'd1;
    end

    de_d = ({1'b0, pix_q} < H_ACT) && ({1'b0, line_q} < V_ACT);
    hs_d = ({1'b0, pix_q} >= HS_BEG) && ({1'b0, pix_q} < HS_END);
    vs_d = ({1'b0, line_q} >= VS_BEG) && ({1'b0, line_q} < VS_END);
    if (to_idle) begin
      de_d = 1'b0;
      hs_d = 1'b0;
      vs_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      div_q   <= '0;
      pix_q   <= '0;
      line_q  <= '0;
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      div_q <= div_d;
      if (ce) begin
        pix_q  <= pix_d;
        line_q <= line_d;
        de_q   <= de_d;
        hs_q   <= hs_d;
        vs_q   <= vs_d;
      end
      unique case (state_q)
        IDLE:    if (EN) state_q <= RUN;
        RUN:     if (!EN) state_q <= DRAIN;
        DRAIN: begin
          if (EN)             state_q <= RUN;
          else if (frame_end) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign CE          = ce;
  assign PIX         = pix_q;
  assign LINE        = line_q;
  assign FRAME_START = ce && (pix_q == '0) && (line_q == '0);
  assign DE          = de_q;
  assign HSYNC       = hs_q ? HS_POL : ~HS_POL;
  assign VSYNC       = vs_q ? VS_POL : ~VS_POL;
  assign VGA_R       = de_q ? R_IN : '0;
  assign VGA_G       = de_q ? G_IN : '0;
  assign VGA_B       = de_q ? B_IN : '0;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: two small-geometry instances checked every cycle
// against an arithmetic CE-count model, plus hand-computed timing literals.
module tb_vga_timing_ctrl;

  logic       CLK;
  logic       RST_N;
  logic       en    [2];
  logic [2:0] r_in  [2];
  logic [2:0] g_in  [2];
  logic [1:0] b_in  [2];
  bit         rand_en;
  bit         const_rgb;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int DIV = (k == 0) ? 2 : 1;
    localparam int HA  = (k == 0) ? 8 : 5;
    localparam int HFP = (k == 0) ? 2 : 1;
    localparam int HSW = (k == 0) ? 3 : 2;
    localparam int HBP = (k == 0) ? 2 : 1;
    localparam int VA  = (k == 0) ? 6 : 4;
    localparam int VFP = 1;
    localparam int VSW = (k == 0) ? 2 : 1;
    localparam int VBP = (k == 0) ? 2 : 1;
    localparam bit HSP = (k == 1);
    localparam bit VSP = (k == 1);
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int FT  = HT * VT;
    // Hand-computed: frame period, HSYNC/VSYNC widths in CLKs, first-CE latency
    localparam int PER_LIT   = (k == 0) ? 330 : 63;
    localparam int HWID_LIT  = (k == 0) ? 6 : 2;
    localparam int VWID_LIT  = (k == 0) ? 60 : 9;
    localparam int FIRST_LIT = (k == 0) ? 2 : 1;

    logic       ce, hs, vs, de, fs;
    logic [9:0] pix, line;
    logic [2:0] vr, vg;
    logic [1:0] vb;

    vga_timing_ctrl #(
      .CLK_DIV (DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HS_POL(HSP), .VS_POL(VSP)
    ) dut (
      .CLK(CLK), .RST_N(RST_N), .EN(en[k]), .CE(ce), .PIX(pix), .LINE(line),
      .R_IN(r_in[k]), .G_IN(g_in[k]), .B_IN(b_in[k]),
      .VGA_R(vr), .VGA_G(vg), .VGA_B(vb),
      .HSYNC(hs), .VSYNC(vs), .DE(de), .FRAME_START(fs)
    );

    // Model: mode 0 idle / 1 run / 2 drain; t = CLKs since leaving idle;
    // n = CEs since leaving idle, so PIX/LINE are n mod the frame geometry.
    int     mode;
    longint t, n;
    logic   ce_m, fend_m;
    assign ce_m   = (mode != 0) && ((t % DIV) == DIV - 1);
    assign fend_m = ce_m && ((n % FT) == FT - 1);

    always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        mode <= 0;
        t    <= 0;
        n    <= 0;
      end else begin
        t <= (mode == 0) ? 0 : t + 1;
        if (ce_m) n <= n + 1;
        case (mode)
          0: if (en[k]) mode <= 1;
          1: if (!en[k]) mode <= 2;
          default: begin
            if (en[k]) mode <= 1;
            else if (fend_m) begin
              mode <= 0;
              n    <= 0;
            end
          end
        endcase
      end
    end

    longint cyc = 0, last_fs = 0, since = 0;
    bit     have_fs = 0, seen_ce = 0;
    int     hrun = 0, vrun = 0;

    always @(posedge CLK) begin : cmp
      longint     pe, le, p, l;
      logic       de_e, hs_a, vs_a, fs_e;
      logic [2:0] re, ge;
      logic [1:0] be;
      logic [32:0] ev, av;
      #1;
      cyc++;
      pe = n % HT;
      le = (n / HT) % VT;
      de_e = 1'b0; hs_a = 1'b0; vs_a = 1'b0;
      if (n > 0) begin
        p = (n - 1) % HT;
        l = ((n - 1) / HT) % VT;
        de_e = (p < HA) && (l < VA);
        hs_a = (p >= HA + HFP) && (p < HA + HFP + HSW);
        vs_a = (l >= VA + VFP) && (l < VA + VFP + VSW);
      end
      fs_e = ce_m && (pe == 0) && (le == 0);
      re = de_e ? r_in[k] : 3'd0;
      ge = de_e ? g_in[k] : 3'd0;
      be = de_e ? b_in[k] : 2'd0;
      ev = {ce_m, 10'(pe), 10'(le), re, ge, be,
            hs_a ? HSP : !HSP, vs_a ? VSP : !VSP, de_e, fs_e};
      av = {ce, pix, line, vr, vg, vb, hs, vs, de, fs};
      chk($sformatf("outputs_dut%0d", k), 64'(av), 64'(ev));

      if (mode == 0) begin
        have_fs = 0;
        seen_ce = 0;
        since   = 0;
      end else begin
        since++;
        if (ce && !seen_ce) begin
          seen_ce = 1;
          chk($sformatf("first_ce_latency_dut%0d", k), 64'(since), 64'(FIRST_LIT));
          chk($sformatf("first_ce_frame_start_dut%0d", k), 64'(fs), 64'd1);
        end
      end
      if (fs) begin
        if (have_fs)
          chk($sformatf("frame_period_dut%0d", k), 64'(cyc - last_fs), 64'(PER_LIT));
        have_fs = 1;
        last_fs = cyc;
      end

      if (!RST_N) begin
        hrun = 0;
        vrun = 0;
      end else begin
        if (hs == HSP) hrun++;
        else begin
          if (hrun > 0) chk($sformatf("hsync_width_dut%0d", k), 64'(hrun), 64'(HWID_LIT));
          hrun = 0;
        end
        if (vs == VSP) vrun++;
        else begin
          if (vrun > 0) chk($sformatf("vsync_width_dut%0d", k), 64'(vrun), 64'(VWID_LIT));
          vrun = 0;
        end
      end
    end
  end

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        if (const_rgb) begin
          r_in[i] = 3'd7; g_in[i] = 3'd7; b_in[i] = 2'd3;
        end else begin
          r_in[i] = 3'($urandom_range(7));
          g_in[i] = 3'($urandom_range(7));
          b_in[i] = 2'($urandom_range(3));
        end
        if (rand_en && $urandom_range(199) == 0) en[i] = !en[i];
      end
    end
  endtask

  task automatic chk_idle(input string nm, input logic ce, input logic [9:0] pix,
                          input logic [9:0] line, input logic hs, input logic vs,
                          input logic de, input logic [2:0] r, input logic [2:0] gg,
                          input logic [1:0] b, input logic fs, input logic hs_idle,
                          input logic vs_idle);
    chk({nm, "_ce"},    64'(ce),   64'd0);
    chk({nm, "_pix"},   64'(pix),  64'd0);
    chk({nm, "_line"},  64'(line), 64'd0);
    chk({nm, "_hsync"}, 64'(hs),   64'(hs_idle));
    chk({nm, "_vsync"}, 64'(vs),   64'(vs_idle));
    chk({nm, "_de"},    64'(de),   64'd0);
    chk({nm, "_vga"},   64'({r, gg, b}), 64'd0);
    chk({nm, "_fs"},    64'(fs),   64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lim;
    RST_N = 1'b0;
    rand_en = 0;
    const_rgb = 1;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; r_in[i] = '0; g_in[i] = '0; b_in[i] = '0;
    end
    repeat (3) @(negedge CLK);
    chk_idle("reset0", g[0].ce, g[0].pix, g[0].line, g[0].hs, g[0].vs, g[0].de,
             g[0].vr, g[0].vg, g[0].vb, g[0].fs, 1'b1, 1'b1);
    chk_idle("reset1", g[1].ce, g[1].pix, g[1].line, g[1].hs, g[1].vs, g[1].de,
             g[1].vr, g[1].vg, g[1].vb, g[1].fs, 1'b0, 1'b0);
    RST_N = 1'b1;
    step(4);

    // Run with full-scale RGB to check blanking, then random RGB
    en[0] = 1'b1; en[1] = 1'b1;
    step(400);
    const_rgb = 0;
    step(400);

    // Asynchronous reset mid-frame
    lim = 0;
    while (!(g[0].pix == 10'd10 && g[0].line == 10'd3) && lim < 400) begin
      step(1);
      lim++;
    end
    chk("reach_mid_frame", 64'(lim < 400), 64'd1);
    #2 RST_N = 1'b0;
    #1;
    chk_idle("async_rst0", g[0].ce, g[0].pix, g[0].line, g[0].hs, g[0].vs, g[0].de,
             g[0].vr, g[0].vg, g[0].vb, g[0].fs, 1'b1, 1'b1);
    chk_idle("async_rst1", g[1].ce, g[1].pix, g[1].line, g[1].hs, g[1].vs, g[1].de,
             g[1].vr, g[1].vg, g[1].vb, g[1].fs, 1'b0, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    step(300);

    // Stop: instance 1 exactly on its last pixel of the frame, instance 0 mid-frame
    lim = 0;
    while (!(g[1].pix == 10'd8 && g[1].line == 10'd6) && lim < 200) begin
      step(1);
      lim++;
    end
    chk("reach_frame_end", 64'(lim < 200), 64'd1);
    en[1] = 1'b0;
    en[0] = 1'b0;
    step(700);
    chk_idle("drained0", g[0].ce, g[0].pix, g[0].line, g[0].hs, g[0].vs, g[0].de,
             g[0].vr, g[0].vg, g[0].vb, g[0].fs, 1'b1, 1'b1);
    chk_idle("drained1", g[1].ce, g[1].pix, g[1].line, g[1].hs, g[1].vs, g[1].de,
             g[1].vr, g[1].vg, g[1].vb, g[1].fs, 1'b0, 1'b0);

    // Restart, then a short stop request withdrawn during the drain
    en[0] = 1'b1; en[1] = 1'b1;
    step(400);
    en[0] = 1'b0; en[1] = 1'b0;
    step(40);
    en[0] = 1'b1; en[1] = 1'b1;
    step(800);

    // Random start/stop traffic
    rand_en = 1;
    step(6000);
    rand_en = 0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Timing controller that sequences the pixel image source.
- Generates the pixel clock enable (CE) and the PIX/LINE scan counters that drive the image source.
- Generates HSYNC, VSYNC and DE aligned to the image source's one-CE registered RGB output, and blanks the RGB outputs to the VGA connector.
- Supports orderly start and stop: a stop request completes the current frame before halting.

Parameters:
- CLK_DIV, 2: CLK cycles per pixel (CE period); must be ≥1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HS_POL, 0: HSYNC level during the sync pulse.
- VS_POL, 0: VSYNC level during the sync pulse.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- EN  in  1  run request; level-sensitive.
- CE  out  1  pixel enable; one CLK cycle wide, drives the image source CE.
- PIX  out  10  horizontal counter, 0..H_TOTAL-1.
- LINE  out  10  vertical counter, 0..V_TOTAL-1.
- R_IN  in  3  red from the image source.
- G_IN  in  3  green from the image source.
- B_IN  in  2  blue from the image source.
- VGA_R  out  3  red to the connector, blanked.
- VGA_G  out  3  green to the connector, blanked.
- VGA_B  out  2  blue to the connector, blanked.
- HSYNC  out  1  horizontal sync.
- VSYNC  out  1  vertical sync.
- DE  out  1  display enable, pipeline-aligned.
- FRAME_START  out  1  one-CLK pulse at the start of each frame.

Behaviour:
- Definitions: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (RST_N=0, asynchronous): state IDLE, divider=0, PIX=0, LINE=0, CE=0, DE=0, HSYNC=~HS_POL, VSYNC=~VS_POL, VGA_R/G/B=0, FRAME_START=0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on EN=1; divider cleared on entry.
  - RUN→DRAIN on EN=0.
  - DRAIN→RUN on EN=1, with no interruption to timing.
  - DRAIN→IDLE on the CE where PIX=H_TOTAL-1 and LINE=V_TOTAL-1; PIX and LINE become 0.
  - IDLE behaves as reset state except that RST_N is high.
- Divider: counts 0..CLK_DIV-1 in RUN/DRAIN. CE=1 (combinational from the registered divider) in the cycle where divider=CLK_DIV-1. The first CE occurs CLK_DIV cycles after entering RUN. With CLK_DIV=1, CE is constant 1 in RUN/DRAIN.
- Counters: on a CLK edge with CE=1:
  - PIX increments, wrapping from H_TOTAL-1 to 0.
  - On that wrap, LINE increments, wrapping from V_TOTAL-1 to 0.
  - PIX and LINE hold between CEs and in IDLE.
- FRAME_START = CE & (PIX==0) & (LINE==0), in RUN/DRAIN only.
- Alignment stage (registered on CE, same edge at which the image source samples PIX/LINE):
  - de_q = PIX<H_ACTIVE & LINE<V_ACTIVE.
  - hs_q = PIX in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs_q = LINE in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Outputs from the alignment stage:
  - DE = de_q.
  - HSYNC = hs_q ? HS_POL : ~HS_POL.
  - VSYNC = vs_q ? VS_POL : ~VS_POL.
  - VGA_x = de_q ? x_IN : 0 (combinational gating of registered signals).
  - Total latency PIX→connector is one CE, matching the image source.
- Entry to IDLE: alignment registers are cleared on the same edge.
- Simultaneous EN=0 and frame end while in RUN: go to DRAIN; DRAIN then runs one more full frame.
- Counter widths: 10 bits; H_TOTAL and V_TOTAL must be ≤1024.

Test Plan:
- Reset mid-frame: assert RST_N=0 at PIX=300, LINE=200 → in the same cycle, without waiting for a CLK edge: CE=0, PIX=LINE=0, HSYNC=VSYNC=1, DE=0, VGA=0.
- Line timing (defaults, EN=1): CE every 2nd CLK; 800 CEs per line; DE high for 640 consecutive CEs; HSYNC low for exactly 96 CEs, going low on the CE edge at which PIX steps 656→657.
- Frame timing: VSYNC low while aligned LINE is 490..491 (2 lines). FRAME_START period is 840000 CLK. The first FRAME_START coincides with the first CE after leaving IDLE.
- Blanking: R_IN=7, G_IN=7, B_IN=3 constant → VGA outputs 7/7/3 only while DE=1, 0/0/0 otherwise, including PIX 640..799 and LINE ≥480.
- Stop/restart:
  - EN=0 at LINE=100 → timing continues to LINE=524, PIX=799; then IDLE, CE stops, PIX=LINE=0, syncs inactive.
  - EN=1 again during DRAIN → no gap; FRAME_START period stays 840000.
- Polarity/divider: HS_POL=1, VS_POL=1, CLK_DIV=1 → HSYNC/VSYNC idle 0 and pulse 1; CE constantly 1 in RUN; line length 800 CLK.
